gfx_vram_writer: RTL and testbench

- CPU-side write port that sits directly upstream of graphics_card's video RAM. It accepts character/colour writes from the CPU bus and buffers them in a small FIFO.
- It commits buffered writes into the single-port VRAM only during blanking, so the renderer's active-video reads are never disturbed.
- It also provides a hardware screen-clear command that fills the whole text buffer with a fill value.

---
 rtl/gfx_pkg.sv | 26 ++
 rtl/gfx_wr_fifo.sv | 73 +++++++
 rtl/gfx_vram_writer.sv | 142 ++++++++++++++
 tb/tb_gfx_vram_writer.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gfx_pkg.sv
// Shared definitions for the graphics card's VRAM write path and renderer.
package gfx_pkg;

    // Text-mode geometry: 800x600 with 8x16 glyphs gives 100 columns by 37 rows.
    localparam int GFX_COLS = 100;
    localparam int GFX_ROWS = 37;

    // VRAM organisation defaults.
    localparam int          GFX_ADDR_W      = 12;
    localparam int          GFX_DATA_W      = 8;
    localparam int          GFX_CLEAR_WORDS = GFX_COLS * GFX_ROWS;
    localparam logic [7:0]  GFX_FILL_VAL    = 8'h20;

    // Writer control states.
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CLR_WAIT = 2'd1,
        CLEAR    = 2'd2
    } gfx_wr_state_t;

    // Linear VRAM address of a text cell.
    function automatic int gfx_cell_addr(input int row, input int col);
        return row * GFX_COLS + col;
    endfunction

endpackage

// File: rtl/gfx_wr_fifo.sv
// Small synchronous FIFO holding pending {addr,data} VRAM writes.
// The head entry is presented combinationally so the writer can register it
// straight into the VRAM port on the cycle it is popped.
module gfx_wr_fifo #(
    parameter int WIDTH = 20,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             do_push;
    logic             do_pop;

    // A push into a full FIFO or a pop from an empty one is dropped.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    assign full  = (count_q == (PTR_W + 1)'(DEPTH));
    assign empty = (count_q == '0);
    assign head  = mem_q[rd_ptr_q];

    // Pointer and level update; simultaneous push/pop leaves the level unchanged.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (PTR_W + 1)'(1);
            2'b01:   count_d = count_q - (PTR_W + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Control state; reset empties the FIFO.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents are only meaningful between the pointers.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/gfx_vram_writer.sv
// CPU-side VRAM write port. CPU writes are buffered and committed to the
// single-port VRAM only on blanking cycles, so the renderer's active-video
// reads never collide with a write. A clear command fills the text buffer.
module gfx_vram_writer
    import gfx_pkg::*;
#(
    parameter int                ADDR_W      = GFX_ADDR_W,
    parameter int                DATA_W      = GFX_DATA_W,
    parameter int                FIFO_DEPTH  = 8,
    parameter int                CLEAR_WORDS = GFX_CLEAR_WORDS,
    parameter logic [DATA_W-1:0] FILL_VAL    = GFX_FILL_VAL
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              clr_start,
    output logic              busy,
    input  logic              video_enable_next,
    output logic              vram_we,
    output logic [ADDR_W-1:0] vram_addr,
    output logic [DATA_W-1:0] vram_wdata
);

    localparam int                ENTRY_W   = ADDR_W + DATA_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(CLEAR_WORDS - 1);

    gfx_wr_state_t     state_q, state_d;
    logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
    logic              busy_q, busy_d;
    logic              vram_we_q, vram_we_d;
    logic [ADDR_W-1:0] vram_addr_q, vram_addr_d;
    logic [DATA_W-1:0] vram_wdata_q, vram_wdata_d;

    logic [ENTRY_W-1:0] fifo_head;
    logic               fifo_full;
    logic               fifo_empty;
    logic               push;
    logic               pop;
    logic               commit_slot;

    // The next cycle is blanking, so a write registered now lands outside active video.
    assign commit_slot = !video_enable_next;

    // CPU writes are only taken while idle, which keeps the FIFO empty during a clear.
    assign wr_ready = !fifo_full && (state_q == IDLE);
    assign push     = wr_valid && wr_ready;
    assign pop      = commit_slot && !fifo_empty && (state_q != CLEAR);

    gfx_wr_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data ({wr_addr, wr_data}),
        .pop       (pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Next-state and VRAM port selection: drained FIFO entries first, then clear words.
    always_comb begin
        state_d      = state_q;
        clr_cnt_d    = clr_cnt_q;
        busy_d       = busy_q;
        vram_we_d    = 1'b0;
        vram_addr_d  = vram_addr_q;
        vram_wdata_d = vram_wdata_q;

        if (pop) begin
            vram_we_d    = 1'b1;
            vram_addr_d  = fifo_head[ENTRY_W-1:DATA_W];
            vram_wdata_d = fifo_head[DATA_W-1:0];
        end

        case (state_q)
            IDLE: begin
                // busy_q can still be high for the one cycle after a clear finishes;
                // a request in that cycle is ignored, not deferred.
                busy_d = 1'b0;
                if (clr_start && !busy_q) begin
                    state_d = CLR_WAIT;
                    busy_d  = 1'b1;
                end
            end
            CLR_WAIT: begin
                busy_d = 1'b1;
                if (fifo_empty) begin
                    state_d   = CLEAR;
                    clr_cnt_d = '0;
                end
            end
            CLEAR: begin
                busy_d = 1'b1;
                if (commit_slot) begin
                    vram_we_d    = 1'b1;
                    vram_addr_d  = clr_cnt_q;
                    vram_wdata_d = FILL_VAL;
                    if (clr_cnt_q == LAST_ADDR) begin
                        state_d = IDLE;
                    end else begin
                        clr_cnt_d = clr_cnt_q + ADDR_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Registered control and VRAM port; reset abandons any clear or drain in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            clr_cnt_q    <= '0;
            busy_q       <= 1'b0;
            vram_we_q    <= 1'b0;
            vram_addr_q  <= '0;
            vram_wdata_q <= '0;
        end else begin
            state_q      <= state_d;
            clr_cnt_q    <= clr_cnt_d;
            busy_q       <= busy_d;
            vram_we_q    <= vram_we_d;
            vram_addr_q  <= vram_addr_d;
            vram_wdata_q <= vram_wdata_d;
        end
    end

    assign busy       = busy_q;
    assign vram_we    = vram_we_q;
    assign vram_addr  = vram_addr_q;
    assign vram_wdata = vram_wdata_q;

endmodule

// File: tb/tb_gfx_vram_writer.sv
// Bench for gfx_vram_writer: a write scoreboard checks every strobe, plus
// directed timing checks with literal expectations.
module tb_gfx_vram_writer;

    localparam int         CW   = 3700;
    localparam logic [7:0] FILL = 8'h20;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [11:0] wr_addr = '0;
    logic [7:0]  wr_data = '0;
    logic        clr_start = 1'b0;
    logic        busy;
    logic        video_enable_next = 1'b0;
    logic        vram_we;
    logic [11:0] vram_addr;
    logic [7:0]  vram_wdata;

    always #5 clk = ~clk;

    gfx_vram_writer #(
        .ADDR_W      (12),
        .DATA_W      (8),
        .FIFO_DEPTH  (8),
        .CLEAR_WORDS (CW),
        .FILL_VAL    (FILL)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .wr_valid          (wr_valid),
        .wr_ready          (wr_ready),
        .wr_addr           (wr_addr),
        .wr_data           (wr_data),
        .clr_start         (clr_start),
        .busy              (busy),
        .video_enable_next (video_enable_next),
        .vram_we           (vram_we),
        .vram_addr         (vram_addr),
        .vram_wdata        (vram_wdata)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected VRAM writes in commit order: {from_clear, addr, data}.
    logic [20:0] sb[$];

    int   ncyc = 0;
    logic ven_s = 1'b0;
    always @(posedge clk) begin
        ncyc  <= ncyc + 1;
        ven_s <= video_enable_next;
    end

    int          stb_cyc[$];
    logic [19:0] stb_rec[$];
    int          n_strobe = 0;
    logic [11:0] last_addr = '0;
    logic [7:0]  last_data = '0;
    bit          last_was_final = 1'b0;

    // Per-cycle compare against the scoreboard and the blanking rule.
    always @(negedge clk) begin
        logic [20:0] e;
        if (!rst) begin
            last_addr      = '0;
            last_data      = '0;
            last_was_final = 1'b0;
        end else begin
            if (last_was_final) begin
                chk("busy_after_last_clear", busy, 0);
                last_was_final = 1'b0;
            end
            if (vram_we) begin
                n_strobe++;
                stb_cyc.push_back(ncyc);
                stb_rec.push_back({vram_addr, vram_wdata});
                chk("strobe_only_after_blank", ven_s, 0);
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_strobe: got addr 0x%0h data 0x%0h, expected no write",
                             vram_addr, vram_wdata);
                end else begin
                    e = sb.pop_front();
                    chk("strobe_addr", vram_addr, e[19:8]);
                    chk("strobe_data", vram_wdata, e[7:0]);
                    if (e[20] && (e[19:8] == 12'(CW - 1))) begin
                        chk("busy_at_last_clear", busy, 1);
                        last_was_final = 1'b1;
                    end
                end
                last_addr = vram_addr;
                last_data = vram_wdata;
            end else begin
                chk("hold_addr", vram_addr, last_addr);
                chk("hold_data", vram_wdata, last_data);
            end
        end
    end

    task automatic push_clear();
        for (int i = 0; i < CW; i++) sb.push_back({1'b1, 12'(i), FILL});
    endtask

    // Call at posedge+1; returns the negedge index at which ready was seen.
    task automatic do_write(input logic [11:0] a, input logic [7:0] d, input bit with_clr,
                            output int acc_cyc);
        bit ok;
        ok       = 1'b0;
        acc_cyc  = -1;
        wr_valid = 1'b1;
        wr_addr  = a;
        wr_data  = d;
        clr_start = with_clr;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (wr_ready) begin
                ok      = 1'b1;
                acc_cyc = ncyc;
                sb.push_back({1'b0, a, d});
                if (with_clr) push_clear();
            end else if (i < 99) begin
                @(posedge clk);
                #1;
            end
        end
        if (!ok) begin
            n_checks++;
            n_fail++;
            $display("FAIL write_timeout: got wr_ready 0 for 100 cycles, expected 1");
        end
        @(posedge clk);
        #1;
        wr_valid  = 1'b0;
        clr_start = 1'b0;
    endtask

    task automatic start_clear();
        clr_start = 1'b1;
        @(negedge clk);
        chk("clear_request_idle", busy, 0);
        push_clear();
        @(posedge clk);
        #1;
        clr_start = 1'b0;
    endtask

    // Wait until all expected writes have appeared, optionally toggling video_enable_next.
    task automatic wait_drain(input int bound, input int toggle_period);
        bit done;
        done = 1'b0;
        for (int i = 0; i < bound && !done; i++) begin
            @(posedge clk);
            #1;
            if (toggle_period > 0 && (i % toggle_period) == toggle_period - 1)
                video_enable_next = ~video_enable_next;
            @(negedge clk);
            if (sb.size() == 0) done = 1'b1;
        end
        chk("drain_complete_remaining", sb.size(), 0);
    endtask

    initial begin
        int k0, k1, k2, m, n0;
        bit found;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_vram_we", vram_we, 0);
        chk("reset_vram_addr", vram_addr, 0);
        chk("reset_vram_wdata", vram_wdata, 0);
        chk("reset_busy", busy, 0);
        chk("reset_wr_ready", wr_ready, 1);
        #1 rst = 1'b1;

        // Idle with blanking
        repeat (10) begin
            @(negedge clk);
            chk("idle_wr_ready", wr_ready, 1);
            chk("idle_busy", busy, 0);
        end
        chk("idle_no_strobes", n_strobe, 0);

        // Three writes in blanking
        @(posedge clk);
        #1;
        stb_cyc.delete();
        stb_rec.delete();
        do_write(12'h000, 8'h41, 1'b0, k0);
        do_write(12'h001, 8'h42, 1'b0, k1);
        do_write(12'h064, 8'h43, 1'b0, k2);
        repeat (6) @(negedge clk);
        chk("three_write_count", stb_cyc.size(), 3);
        if (stb_cyc.size() >= 3) begin
            chk("w0_latency", stb_cyc[0], k0 + 2);
            chk("w1_latency", stb_cyc[1], k1 + 2);
            chk("w2_latency", stb_cyc[2], k2 + 2);
            chk("w0_literal", stb_rec[0], 20'h000_41);
            chk("w1_literal", stb_rec[1], 20'h001_42);
            chk("w2_literal", stb_rec[2], 20'h064_43);
        end

        // Fill the FIFO during active video, then release it
        @(posedge clk);
        #1;
        video_enable_next = 1'b1;
        for (int i = 0; i < 8; i++) do_write(12'h100 + 12'(i), 8'h80 + 8'(i), 1'b0, k0);
        @(negedge clk);
        chk("full_wr_ready", wr_ready, 0);
        n0 = n_strobe;
        repeat (4) @(negedge clk);
        chk("active_no_strobes", n_strobe, n0);
        chk("full_busy", busy, 0);
        stb_cyc.delete();
        stb_rec.delete();
        @(posedge clk);
        #1;
        video_enable_next = 1'b0;
        @(negedge clk);
        m = ncyc;
        chk("ready_before_first_pop", wr_ready, 0);
        @(negedge clk);
        chk("ready_after_first_pop", wr_ready, 1);
        repeat (10) @(negedge clk);
        chk("burst_count", stb_cyc.size(), 8);
        for (int i = 0; i < 8 && i < stb_cyc.size(); i++)
            chk("burst_consecutive", stb_cyc[i], m + 1 + i);
        if (stb_rec.size() == 8) chk("burst_last_literal", stb_rec[7], 20'h107_87);

        // Clear together with a write, blanking throughout
        @(posedge clk);
        #1;
        n0 = n_strobe;
        do_write(12'h010, 8'h58, 1'b1, k0);
        @(negedge clk);
        chk("busy_after_clear_request", busy, 1);
        chk("ready_low_during_clear", wr_ready, 0);
        wait_drain(12000, 0);
        chk("clear_with_write_count", n_strobe - n0, CW + 1);
        repeat (3) @(negedge clk);
        chk("post_clear_busy", busy, 0);
        chk("post_clear_ready", wr_ready, 1);
        chk("post_clear_last_addr", vram_addr, 12'hE73);
        chk("post_clear_last_data", vram_wdata, 8'h20);

        // Clear with video_enable_next toggling every 5 cycles
        @(posedge clk);
        #1;
        n0 = n_strobe;
        start_clear();
        wait_drain(20000, 5);
        chk("toggled_clear_count", n_strobe - n0, CW);
        @(posedge clk);
        #1;
        video_enable_next = 1'b0;
        repeat (3) @(negedge clk);
        chk("toggled_clear_busy_done", busy, 0);

        // Reset in the middle of a clear
        @(posedge clk);
        #1;
        start_clear();
        found = 1'b0;
        for (int i = 0; i < 3000 && !found; i++) begin
            @(negedge clk);
            if (vram_we && vram_addr == 12'd1000) found = 1'b1;
        end
        chk("reached_addr_1000", found, 1);
        #2 rst = 1'b0;
        #1;
        chk("async_reset_vram_we", vram_we, 0);
        chk("async_reset_vram_addr", vram_addr, 0);
        chk("async_reset_vram_wdata", vram_wdata, 0);
        chk("async_reset_busy", busy, 0);
        chk("async_reset_wr_ready", wr_ready, 1);
        sb.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        n0 = n_strobe;
        repeat (20) begin
            @(negedge clk);
            chk("after_reset_busy", busy, 0);
            chk("after_reset_ready", wr_ready, 1);
        end
        chk("after_reset_no_strobes", n_strobe, n0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #(10 * 90000);
        $display("FAIL watchdog: got simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
